stack_core_mc: RTL and testbench
================================

Name: stack_core_mc

Overview:
- Parametrised multi-cycle stack-machine core: controller FSM, datapath, hardware operand stack and PC in one block.
- Talks to a single unified instruction/data memory through a req/ack handshake, so the memory may insert wait states.
- Generalises the fixed-width push/pop/tos processor: word width, address width and stack depth are configurable, and stack faults are detected.
- Instantiated under a top alongside a memory model.

Parameters:
- DATA_W, 8, word width; instruction = opcode[DATA_W-1:DATA_W-3] + address[ADDR_W-1:0]; DATA_W >= ADDR_W+3 required.
- ADDR_W, 5, memory address width and PC width.
- STACK_DEPTH, 8, operand stack entries; must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  address; stable while mem_req=1
- mem_wdata  out  DATA_W  write data; stable while mem_req=1
- mem_rdata  in  DATA_W  read data; sampled in the ack cycle
- mem_ack  in  1  transfer completes in the cycle it is high with mem_req
- pc  out  ADDR_W  program counter
- depth  out  $clog2(STACK_DEPTH+1)  current stack occupancy
- tos  out  DATA_W  top-of-stack value; 0 when depth=0
- retire  out  1  one-cycle pulse per completed instruction
- fault  out  1  sticky fault flag
- fault_code  out  2  00 none, 01 overflow, 10 underflow

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named clk and reset.
- Reset values: pc=0, depth=0, all mem_* outputs 0, retire=0, fault=0, fault_code=00, IR=0, state=FETCH.
- Reset mid-transaction aborts it; mem_req is 0 after that edge. mem_ack arriving while in reset is ignored.
- Opcodes (A=TOS, B=next):
  - 000 ADD: pop 2, push B+A
  - 001 SUB: pop 2, push B-A
  - 010 AND: pop 2, push B&A
  - 011 NOT: replace TOS with ~A
  - 100 PUSH addr: push mem[addr]
  - 101 POP addr: mem[addr]=A, pop
  - 110 JMP addr: pc=addr
  - 111 JZ addr: if A==0 then pc=addr; TOS is not popped
- Arithmetic is modulo 2^DATA_W; carry is discarded.
- FSM states: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, FAULT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - In the ack cycle: IR<=mem_rdata, pc<=pc+1 (wraps at 2^ADDR_W) -> DECODE.
  - mem_req drops on the next edge.
- DECODE (1 cycle):
  - Stack check: ALU binary ops need depth>=2; NOT/POP/JZ need depth>=1; PUSH needs depth<STACK_DEPTH.
  - Check failure -> FAULT.
  - PUSH -> MEM_RD; POP -> MEM_WR; others -> EXEC.
- EXEC (1 cycle): update stack or pc; retire=1 -> FETCH.
- MEM_RD: read at IR address; in the ack cycle push mem_rdata, retire=1 -> FETCH.
- MEM_WR:
  - mem_we=1, mem_wdata=A at IR address.
  - In the ack cycle: pop, retire=1 -> FETCH.
- Latency with zero-wait memory (ack in the first req cycle):
  - ALU/JMP/JZ: 3 cycles.
  - PUSH/POP: 4 cycles.
  - Each wait cycle adds 1.
- FAULT:
  - Terminal: no memory requests, pc/stack frozen, fault=1, fault_code set.
  - Only reset exits FAULT. The faulting instruction does not retire.
- pc after a fault points to the instruction following the faulting one.
- JZ/JMP to the current pc forms a legal infinite loop; no special handling.
- depth never exceeds STACK_DEPTH.

Optional Feature:
- Macro: STACK_CHECK_EN.
- Defined: DECODE performs the depth checks above; overflow/underflow enter FAULT.
- Undefined:
  - No checks; FAULT is unreachable; fault/fault_code are tied to 0.
  - Stack pointer wraps modulo STACK_DEPTH.
  - depth saturates at 0 and STACK_DEPTH.
  - Underflow reads return the stale entry.

Test Plan:
- Add/store: mem[10]=3, mem[11]=4, program PUSH 10; PUSH 11; ADD; POP 12, zero-wait memory -> mem[12]=7, depth=0, 4 retire pulses, 15 cycles from reset release to last retire.
- Subtract and branch:
  - mem[10]=5, mem[11]=5, program PUSH 10; PUSH 11; SUB; JZ 8.
  - Expected: pc=8 after JZ, tos=0, depth=1.
  - Repeat with mem[11]=2: tos=3, pc=4 (no branch).
- Wait states: ack delayed 3 cycles on every request, add/store program -> same results; each instruction takes 3 extra cycles per memory access; mem_addr/mem_we/mem_wdata stable while mem_req=1.
- Overflow (STACK_CHECK_EN, depth 8): nine consecutive PUSH 20 -> after the 9th DECODE fault=1, fault_code=01, depth=8, pc=9, no further mem_req.
- Underflow: first instruction ADD with empty stack -> fault_code=10, retire never pulses. Without STACK_CHECK_EN -> no fault, depth=1 after ADD, pc=1.
- Reset mid-op: assert reset during a MEM_WR wait state -> next cycle mem_req=0, pc=0, depth=0; mem[addr] not written; execution restarts at address 0.

Source files
------------

// File: rtl/stack_core_mc.sv
// stack_core_mc: multi-cycle stack machine (controller FSM, datapath, operand stack, PC) on one req/ack memory port.
// Optional macro STACK_CHECK_EN: DECODE-time overflow/underflow checks and a terminal FAULT state.
module stack_core_mc #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 8,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH+1),
  localparam int SP_W       = $clog2(STACK_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  pc,
  output logic [DEPTH_W-1:0] depth,
  output logic [DATA_W-1:0]  tos,
  output logic               retire,
  output logic               fault,
  output logic [1:0]         fault_code
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_RD, S_MEM_WR, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_NOT, OP_PUSH, OP_POP, OP_JMP, OP_JZ
  } op_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]    SP_LAST   = SP_W'(STACK_DEPTH-1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [DATA_W-1:0]  stk_q [STACK_DEPTH];
  logic [DATA_W-1:0]  stk_d [STACK_DEPTH];
  logic               armed_q, armed_d;

  logic               req_c, we_c, retire_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [DATA_W-1:0]  wdata_c;

  // sp points at the next free slot; it wraps so stale entries are reused when unchecked
  function automatic logic [SP_W-1:0] sp_inc(input logic [SP_W-1:0] s);
    return (s == SP_LAST) ? '0 : s + SP_W'(1);
  endfunction

  function automatic logic [SP_W-1:0] sp_dec(input logic [SP_W-1:0] s);
    return (s == '0) ? SP_LAST : s - SP_W'(1);
  endfunction

  op_t               op;
  logic [ADDR_W-1:0] ir_addr;
  logic [SP_W-1:0]   a_idx, b_idx;
  logic [DATA_W-1:0] a, b;

  assign op      = op_t'(ir_q[DATA_W-1 -: 3]);
  assign ir_addr = ir_q[ADDR_W-1:0];
  assign a_idx   = sp_dec(sp_q);
  assign b_idx   = sp_dec(a_idx);
  assign a       = stk_q[a_idx];
  assign b       = stk_q[b_idx];

`ifdef STACK_CHECK_EN
  logic [1:0] fault_code_q, fault_code_d;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    sp_d     = sp_q;
    depth_d  = depth_q;
    stk_d    = stk_q;
    armed_d  = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = '0;
    wdata_c  = '0;
    retire_c = 1'b0;
`ifdef STACK_CHECK_EN
    fault_code_d = fault_code_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        req_c  = 1'b1;
        addr_c = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op == OP_PUSH)     state_d = S_MEM_RD;
        else if (op == OP_POP) state_d = S_MEM_WR;
        else                   state_d = S_EXEC;
`ifdef STACK_CHECK_EN
        if (op == OP_PUSH && depth_q == DEPTH_MAX) begin
          fault_code_d = 2'b01;
          state_d      = S_FAULT;
        end else if (((op == OP_ADD || op == OP_SUB || op == OP_AND) && depth_q < DEPTH_W'(2)) ||
                     ((op == OP_NOT || op == OP_POP || op == OP_JZ) && depth_q == '0)) begin
          fault_code_d = 2'b10;
          state_d      = S_FAULT;
        end
`endif
      end
      S_EXEC: begin
        retire_c = 1'b1;
        state_d  = S_FETCH;
        unique case (op)
          OP_ADD, OP_SUB, OP_AND: begin
            stk_d[b_idx] = (op == OP_ADD) ? b + a : (op == OP_SUB) ? b - a : b & a;
            sp_d         = a_idx;
            // pop two (saturating at empty) then push one
            depth_d      = (depth_q > DEPTH_W'(1)) ? depth_q - DEPTH_W'(1) : DEPTH_W'(1);
          end
          OP_NOT:  stk_d[a_idx] = ~a;
          OP_JMP:  pc_d = ir_addr;
          OP_JZ:   if (a == '0) pc_d = ir_addr;
          default: ;
        endcase
      end
      // Data states spend one cycle arming so address and data come from settled IR/stack
      S_MEM_RD: begin
        addr_c  = ir_addr;
        armed_d = 1'b1;
        if (armed_q) begin
          req_c = 1'b1;
          if (mem_ack) begin
            stk_d[sp_q] = mem_rdata;
            sp_d        = sp_inc(sp_q);
            depth_d     = (depth_q == DEPTH_MAX) ? depth_q : depth_q + DEPTH_W'(1);
            retire_c    = 1'b1;
            armed_d     = 1'b0;
            state_d     = S_FETCH;
          end
        end
      end
      S_MEM_WR: begin
        addr_c  = ir_addr;
        wdata_c = a;
        armed_d = 1'b1;
        if (armed_q) begin
          req_c = 1'b1;
          we_c  = 1'b1;
          if (mem_ack) begin
            sp_d     = a_idx;
            depth_d  = (depth_q == '0) ? depth_q : depth_q - DEPTH_W'(1);
            retire_c = 1'b1;
            armed_d  = 1'b0;
            state_d  = S_FETCH;
          end
        end
      end
      S_FAULT: ;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      sp_q    <= '0;
      depth_q <= '0;
      armed_q <= 1'b0;
      stk_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      armed_q <= armed_d;
      stk_q   <= stk_d;
    end
  end

`ifdef STACK_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) fault_code_q <= 2'b00;
    else       fault_code_q <= fault_code_d;
  end
  assign fault_code = fault_code_q;
`else
  assign fault_code = 2'b00;
`endif

  // Gate with reset so a transaction in flight is dropped in the reset cycle itself
  assign mem_req   = req_c & ~reset;
  assign mem_we    = we_c & ~reset;
  assign mem_addr  = addr_c;
  assign mem_wdata = wdata_c;
  assign retire    = retire_c & ~reset;
  assign fault     = |fault_code;
  assign pc        = pc_q;
  assign depth     = depth_q;
  assign tos       = (depth_q == '0) ? '0 : a;

endmodule

// File: tb/tb_stack_core_mc.sv
// tb_stack_core_mc: directed programs against an ISA-level model of the stack machine plus a req/ack memory with wait states.
module tb_stack_core_mc;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_req, mem_we, mem_ack = 1'b0;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_wdata, mem_rdata = '0, tos;
  logic [3:0] depth;
  logic       retire, fault;
  logic [1:0] fault_code;

  stack_core_mc #(.DATA_W(8), .ADDR_W(5), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .depth(depth), .tos(tos), .retire(retire), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_retire = 0, last_ret_cyc = 0, cyc = 0, wcnt = 0, wait_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory with programmable wait states ----------------
  logic [7:0] mem [32];
  logic       x_req = 1'b0, x_ack = 1'b0, x_we = 1'b0;
  logic [4:0] x_addr = '0;
  logic [7:0] x_wdata = '0;

  always @(negedge clk) begin
    #1;
    mem_ack   = !reset && mem_req && (wcnt == wait_n);
    mem_rdata = mem_ack ? mem[mem_addr] : 8'hA5;
    x_req = mem_req && !reset; x_ack = mem_ack; x_we = mem_we;
    x_addr = mem_addr; x_wdata = mem_wdata;
  end

  always @(posedge clk) begin
    if (reset) begin
      wcnt = 0; cyc = 0;
    end else begin
      cyc++;
      if (x_req) begin
        if (x_ack) begin
          if (x_we) mem[x_addr] = x_wdata;
          wcnt = 0;
        end else wcnt++;
      end
    end
  end

  // ---------------- ISA-level reference model ----------------
  logic [7:0] m_mem [32];
  logic [7:0] m_stk [8];
  logic [4:0] m_pc;
  int         m_sp, m_depth;

  task automatic m_reset();
    m_pc = '0; m_sp = 0; m_depth = 0;
    for (int i = 0; i < 8; i++) m_stk[i] = '0;
  endtask

  function automatic logic [7:0] m_tos();
    return (m_depth == 0) ? 8'h00 : m_stk[(m_sp + 7) % 8];
  endfunction

  task automatic m_step(output logic [1:0] fc);
    logic [7:0] w, a, b;
    logic [2:0] op;
    logic [4:0] ad;
    w = m_mem[m_pc]; op = w[7:5]; ad = w[4:0];
    m_pc = m_pc + 5'd1;
    a = m_stk[(m_sp + 7) % 8];
    b = m_stk[(m_sp + 6) % 8];
    fc = 2'b00;
`ifdef STACK_CHECK_EN
    if (op == 3'd4 && m_depth == 8) fc = 2'b01;
    else if (op <= 3'd2 && m_depth < 2) fc = 2'b10;
    else if ((op == 3'd3 || op == 3'd5 || op == 3'd7) && m_depth < 1) fc = 2'b10;
`endif
    if (fc == 2'b00) begin
      case (op)
        3'd0, 3'd1, 3'd2: begin
          m_stk[(m_sp + 6) % 8] = (op == 3'd0) ? b + a : (op == 3'd1) ? b - a : b & a;
          m_sp = (m_sp + 7) % 8;
          m_depth = ((m_depth >= 2) ? m_depth - 2 : 0) + 1;
        end
        3'd3: m_stk[(m_sp + 7) % 8] = ~a;
        3'd4: begin
          m_stk[m_sp] = m_mem[ad];
          m_sp = (m_sp + 1) % 8;
          if (m_depth < 8) m_depth++;
        end
        3'd5: begin
          m_mem[ad] = a;
          m_sp = (m_sp + 7) % 8;
          if (m_depth > 0) m_depth--;
        end
        3'd6: m_pc = ad;
        default: if (a == 8'h00) m_pc = ad;
      endcase
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  logic       pending = 1'b0, stab_vld = 1'b0, s_we;
  logic [4:0] s_addr;
  logic [7:0] s_wdata;
  logic [1:0] fc;

  always @(negedge clk) begin
    #2;
    if (reset) begin
      pending = 1'b0; stab_vld = 1'b0; n_retire = 0;
      m_reset();
    end else begin
      if (pending) begin
        check("pc_after_retire", pc, m_pc);
        check("depth_after_retire", depth, m_depth);
        check("tos_after_retire", tos, m_tos());
        pending = 1'b0;
      end
      if (stab_vld && mem_req) begin
        check("addr_stable", mem_addr, s_addr);
        check("we_stable", mem_we, s_we);
        check("wdata_stable", mem_wdata, s_wdata);
      end
      stab_vld = mem_req && !mem_ack;
      s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
      if (fault === 1'b1) check("no_req_in_fault", mem_req, 1'b0);
      if (retire === 1'b1) begin
        n_retire++;
        last_ret_cyc = cyc + 1;
        m_step(fc);
        check("retire_legal", fc, 2'b00);
        pending = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] ad);
    return {op, ad};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  task automatic start(input bit check_reset);
    for (int i = 0; i < 32; i++) m_mem[i] = mem[i];
    reset = 1'b1;
    repeat (2) @(negedge clk);
    if (check_reset) begin
      check("rst_pc", pc, 0);
      check("rst_depth", depth, 0);
      check("rst_tos", tos, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_retire", retire, 0);
      check("rst_fault", fault, 0);
      check("rst_fault_code", fault_code, 0);
    end
    reset = 1'b0;
  endtask

  task automatic wait_retires(input int n, input int budget);
    int g = 0;
    while (n_retire < n && g < budget) begin
      @(negedge clk);
      g++;
    end
    check("retire_count_reached", (n_retire >= n), 1'b1);
  endtask

  task automatic load_add_store();
    clear_mem();
    mem[0] = ins(3'd4, 5'd10); mem[1] = ins(3'd4, 5'd11);
    mem[2] = ins(3'd0, 5'd0);  mem[3] = ins(3'd5, 5'd12);
    mem[4] = ins(3'd6, 5'd4);
    mem[10] = 8'd3; mem[11] = 8'd4;
  endtask

  initial begin
    clear_mem();

    // add/store, zero-wait
    wait_n = 0;
    load_add_store();
    start(1'b1);
    wait_retires(4, 100);
    check("t1_mem12", mem[12], 8'd7);
    check("t1_depth", depth, 0);
    check("t1_tos", tos, 0);
    check("t1_last_retire_cycle", last_ret_cyc, 15);

    // subtract, branch taken
    clear_mem();
    mem[0] = ins(3'd4, 5'd10); mem[1] = ins(3'd4, 5'd11);
    mem[2] = ins(3'd1, 5'd0);  mem[3] = ins(3'd7, 5'd8);
    mem[4] = ins(3'd6, 5'd4);  mem[8] = ins(3'd6, 5'd8);
    mem[10] = 8'd5; mem[11] = 8'd5;
    start(1'b0);
    wait_retires(4, 100);
    check("t2_pc_taken", pc, 8);
    check("t2_tos", tos, 0);
    check("t2_depth", depth, 1);

    // subtract, branch not taken
    mem[11] = 8'd2;
    start(1'b0);
    wait_retires(4, 100);
    check("t2b_pc_fallthru", pc, 4);
    check("t2b_tos", tos, 3);
    check("t2b_depth", depth, 1);

    // add/store with 3 wait states on every access
    wait_n = 3;
    load_add_store();
    start(1'b0);
    wait_retires(4, 300);
    check("t3_mem12", mem[12], 8'd7);
    check("t3_depth", depth, 0);
    check("t3_last_retire_cycle", last_ret_cyc, 36);
    wait_n = 0;

    // nine consecutive pushes
    clear_mem();
    for (int i = 0; i < 9; i++) mem[i] = ins(3'd4, 5'd20);
    mem[9] = ins(3'd6, 5'd9);
    mem[20] = 8'h5A;
    start(1'b0);
`ifdef STACK_CHECK_EN
    repeat (50) @(negedge clk);
    check("ovf_fault", fault, 1);
    check("ovf_code", fault_code, 2'b01);
    check("ovf_depth", depth, 8);
    check("ovf_pc", pc, 9);
    check("ovf_retires", n_retire, 8);
`else
    wait_retires(9, 200);
    check("ovf_nochk_fault", fault, 0);
    check("ovf_nochk_depth", depth, 8);
    check("ovf_nochk_pc", pc, 9);
    check("ovf_nochk_tos", tos, 8'h5A);
`endif

    // ADD on an empty stack
    clear_mem();
    mem[0] = ins(3'd0, 5'd0);
    mem[1] = ins(3'd6, 5'd1);
    start(1'b0);
`ifdef STACK_CHECK_EN
    repeat (20) @(negedge clk);
    check("udf_fault", fault, 1);
    check("udf_code", fault_code, 2'b10);
    check("udf_retires", n_retire, 0);
    check("udf_pc", pc, 1);
    check("udf_depth", depth, 0);
`else
    wait_retires(1, 50);
    check("udf_nochk_fault", fault, 0);
    check("udf_nochk_depth", depth, 1);
    check("udf_nochk_pc", pc, 1);
`endif

    // reset while the POP write is waiting for ack
    wait_n = 3;
    load_add_store();
    start(1'b0);
    begin
      int g = 0;
      while (!(mem_req && mem_we) && g < 300) begin
        @(negedge clk);
        g++;
      end
      check("t6_found_write_wait", (mem_req && mem_we), 1'b1);
    end
    reset = 1'b1;
    @(negedge clk);
    check("t6_req_dropped", mem_req, 0);
    check("t6_pc", pc, 0);
    check("t6_depth", depth, 0);
    check("t6_no_write", mem[12], 8'd0);
    reset = 1'b0;
    wait_retires(4, 300);
    check("t6_restart_mem12", mem[12], 8'd7);
    check("t6_restart_cycle", last_ret_cyc, 36);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
